// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_pkg
// Brief    : Shared types and constants for the ws2812 driver and controllers
// Revision : 1.0
// ============================================================================
package ws2812_pkg;

    localparam int RGB_W     = 24;
    localparam int LED_IDX_W = 8;

    // Driver bit timing in 12 MHz clock cycles.
    localparam int T_ON_CYC    = 10;
    localparam int T_OFF_CYC   = 5;
    localparam int T_RESET_CYC = 600;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2
    } chase_state_t;

    // Right-shift each 8-bit channel of a GRB word independently.
    function automatic logic [RGB_W-1:0] scale_grb(input logic [RGB_W-1:0] c,
                                                   input logic [2:0]       sh);
        return {c[23:16] >> sh, c[15:8] >> sh, c[7:0] >> sh};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_frame_timer
// Brief    : Loadable down-counter with a zero flag for frame pacing
// Revision : 1.0
// ============================================================================
module ws2812_frame_timer #(
    parameter int CNT_W = 21
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ws2812_chase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_chase_ctrl
// Brief    : Chase-animation sequencer owning the ws2812 write port, with host
//            arbitration between bursts. WS2812_BRIGHTNESS_EN adds brightness.
// Revision : 1.0
// ============================================================================
module ws2812_chase_ctrl
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS    = 8,
    parameter int FRAME_TICKS = 1200000,
    parameter int CNT_W       = 21
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 dir,
    input  logic [RGB_W-1:0]     colour,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [2:0]           brightness,
`endif
    input  logic                 host_write,
    input  logic [LED_IDX_W-1:0] host_led_num,
    input  logic [RGB_W-1:0]     host_rgb_data,
    output logic                 host_ready,
    output logic                 frame_done,
    output logic                 write,
    output logic [LED_IDX_W-1:0] led_num,
    output logic [RGB_W-1:0]     rgb_data
);

    localparam logic [LED_IDX_W-1:0] c_LAST_IDX = LED_IDX_W'(NUM_LEDS - 1);

    chase_state_t         state_q, state_d;
    logic [LED_IDX_W-1:0] idx_q, idx_d, head_q, head_d, led_num_q, led_num_d;
    logic [RGB_W-1:0]     latch_q, latch_d, rgb_data_q, rgb_data_d;
    logic                 write_q, write_d, frame_done_q, frame_done_d;
    logic [RGB_W-1:0]     w_colour_in;
    logic                 w_tmr_load, w_tmr_dec, w_tmr_zero, w_accept;
    logic [CNT_W-1:0]     w_tmr_val;

`ifdef WS2812_BRIGHTNESS_EN
    assign w_colour_in = scale_grb(colour, brightness);
`else
    assign w_colour_in = colour;
`endif

    ws2812_frame_timer #(
        .CNT_W (CNT_W)
    ) u_frame_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    // The cycle that launches a burst is reserved for the burst.
    assign host_ready = (state_q != LOAD) &&
                        !(state_q == WAIT && w_tmr_zero && enable);
    assign w_accept   = host_write && host_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        head_d       = head_q;
        latch_d      = latch_q;
        write_d      = 1'b0;
        frame_done_d = 1'b0;
        led_num_d    = led_num_q;
        rgb_data_d   = rgb_data_q;
        w_tmr_load   = 1'b0;
        w_tmr_val    = CNT_W'(FRAME_TICKS - 1);
        w_tmr_dec    = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d    = WAIT;
                    w_tmr_load = 1'b1;
                end
            end
            WAIT: begin
                w_tmr_dec = 1'b1;
                if (!enable) begin
                    state_d = IDLE;
                end else if (w_tmr_zero) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    latch_d = w_colour_in;
                end
            end
            LOAD: begin
                write_d    = 1'b1;
                led_num_d  = idx_q;
                rgb_data_d = (idx_q == head_q) ? latch_q : '0;
                idx_d      = idx_q + LED_IDX_W'(1);
                if (idx_q == c_LAST_IDX) begin
                    frame_done_d = 1'b1;
                    if (dir) begin
                        head_d = (head_q == '0) ? c_LAST_IDX : head_q - LED_IDX_W'(1);
                    end else begin
                        head_d = (head_q == c_LAST_IDX) ? '0 : head_q + LED_IDX_W'(1);
                    end
                    state_d    = enable ? WAIT : IDLE;
                    // One count longer than from IDLE so the burst-start period
                    // is FRAME_TICKS + NUM_LEDS + 1.
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CNT_W'(FRAME_TICKS);
                end
            end
            default: state_d = IDLE;
        endcase

        // Out-of-range host targets are consumed without a write.
        if (w_accept && (host_led_num < LED_IDX_W'(NUM_LEDS))) begin
            write_d    = 1'b1;
            led_num_d  = host_led_num;
            rgb_data_d = host_rgb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            head_q       <= '0;
            latch_q      <= '0;
            write_q      <= 1'b0;
            frame_done_q <= 1'b0;
            led_num_q    <= '0;
            rgb_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            head_q       <= head_d;
            latch_q      <= latch_d;
            write_q      <= write_d;
            frame_done_q <= frame_done_d;
            led_num_q    <= led_num_d;
            rgb_data_q   <= rgb_data_d;
        end
    end

    assign write      = write_q;
    assign frame_done = frame_done_q;
    assign led_num    = led_num_q;
    assign rgb_data   = rgb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_chase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_chase_ctrl
// Brief    : Self-checking bench for ws2812_chase_ctrl (NUM_LEDS=4, FRAME_TICKS=10)
// Revision : 1.0
// ============================================================================
module tb_ws2812_chase_ctrl;

    localparam int N      = 4;
    localparam int FT     = 10;
    localparam int PERIOD = FT + N + 1;

    logic        clk = 1'b0;
    logic        reset, enable, dir, host_write;
    logic [23:0] colour, host_rgb_data;
    logic [7:0]  host_led_num;
`ifdef WS2812_BRIGHTNESS_EN
    logic [2:0]  brightness;
`endif
    logic        host_ready, frame_done, write;
    logic [7:0]  led_num;
    logic [23:0] rgb_data;

    int checks = 0;
    int errors = 0;

    logic        obs_wr [N];
    logic        obs_fd [N];
    logic [7:0]  obs_led[N];
    logic [23:0] obs_rgb[N];
    logic        obs_tail_wr, obs_tail_fd;

    ws2812_chase_ctrl #(.NUM_LEDS(N), .FRAME_TICKS(FT), .CNT_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .dir           (dir),
        .colour        (colour),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness    (brightness),
`endif
        .host_write    (host_write),
        .host_led_num  (host_led_num),
        .host_rgb_data (host_rgb_data),
        .host_ready    (host_ready),
        .frame_done    (frame_done),
        .write         (write),
        .led_num       (led_num),
        .rgb_data      (rgb_data)
    );

    always #5 clk = ~clk;

    // Reference model: a burst is N writes, only the head lit; head steps by +-1 mod N.
    function automatic logic [23:0] exp_rgb(input int i, input int head, input logic [23:0] col);
        return (i == head) ? col : 24'h0;
    endfunction

    function automatic int next_head(input int h, input logic d);
        return d ? (h + N - 1) % N : (h + 1) % N;
    endfunction

    function automatic logic [23:0] dim(input logic [23:0] c, input int b);
        int g, r, bl;
        g  = int'(c[23:16]) / (1 << b);
        r  = int'(c[15:8])  / (1 << b);
        bl = int'(c[7:0])   / (1 << b);
        return {g[7:0], r[7:0], bl[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; dir = 1'b0; colour = 24'h0;
        host_write = 1'b0; host_led_num = 8'h0; host_rgb_data = 24'h0;
`ifdef WS2812_BRIGHTNESS_EN
        brightness = 3'd0;
`endif
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wait_write(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!write && n < limit);
    endtask

    // Records a burst whose first write is visible now, plus the cycle after it.
    task automatic capture_burst(input logic [23:0] next_colour);
        for (int i = 0; i < N; i++) begin
            if (i > 0) tick();
            obs_wr[i] = write; obs_fd[i] = frame_done;
            obs_led[i] = led_num; obs_rgb[i] = rgb_data;
            if (i == 0) colour = next_colour;
        end
        tick();
        obs_tail_wr = write; obs_tail_fd = frame_done;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({write, frame_done, led_num, rgb_data, host_ready} !== {1'b0, 1'b0, 8'h0, 24'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset: got wr=%b fd=%b led=%0d rgb=%h rdy=%b, expected 0 0 0 000000 1",
                     write, frame_done, led_num, rgb_data, host_ready);
        end
    endtask

    task automatic test_chase();
        int head, n;
        logic [23:0] col, nc;
        do_reset();
        colour = 24'h00FF00; enable = 1'b1;
        // Enable is sampled at tick 1; LOAD occupies the cycle after tick 11.
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if ({write, host_ready} !== {1'(k == 12), 1'(k < 10)}) begin
                errors++;
                $display("FAIL chase_start t%0d: got wr=%b rdy=%b, expected wr=%b rdy=%b",
                         k, write, host_ready, k == 12, k < 10);
            end
        end
        head = 0; col = colour;
        for (int b = 0; b < 5; b++) begin
            nc = $urandom;
            capture_burst(nc);
            for (int i = 0; i < N; i++) begin
                checks++;
                if ({obs_wr[i], obs_fd[i], obs_led[i], obs_rgb[i]} !== {1'b1, 1'(i == N-1), 8'(i), exp_rgb(i, head, col)}) begin
                    errors++;
                    $display("FAIL chase b%0d led%0d: got wr=%b fd=%b led=%0d rgb=%h, expected wr=1 fd=%b led=%0d rgb=%h",
                             b, i, obs_wr[i], obs_fd[i], obs_led[i], obs_rgb[i], i == N-1, i, exp_rgb(i, head, col));
                end
            end
            checks++;
            if ({obs_tail_wr, obs_tail_fd} !== 2'b00) begin
                errors++;
                $display("FAIL chase_tail b%0d: got wr=%b fd=%b, expected 0 0", b, obs_tail_wr, obs_tail_fd);
            end
            head = next_head(head, dir); col = nc;
            if (b < 4) begin
                wait_write(40, n);
                checks++;
                if (n != PERIOD - N) begin
                    errors++;
                    $display("FAIL chase_period b%0d: got %0d, expected %0d", b, n, PERIOD - N);
                end
            end
        end
    endtask

    task automatic test_dir();
        int head, n;
        logic [23:0] col, nc;
        do_reset();
        dir = 1'b1; colour = $urandom; enable = 1'b1;
        wait_write(40, n);
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL dir_start: got %0d, expected 12", n);
        end
        head = 0; col = colour;
        for (int b = 0; b < 6; b++) begin
            nc = $urandom;
            capture_burst(nc);
            for (int i = 0; i < N; i++) begin
                checks++;
                if ({obs_wr[i], obs_led[i], obs_rgb[i]} !== {1'b1, 8'(i), exp_rgb(i, head, col)}) begin
                    errors++;
                    $display("FAIL dir b%0d led%0d: got wr=%b led=%0d rgb=%h, expected wr=1 led=%0d rgb=%h",
                             b, i, obs_wr[i], obs_led[i], obs_rgb[i], i, exp_rgb(i, head, col));
                end
            end
            head = next_head(head, dir); col = nc;
            dir = (b < 1) ? 1'b1 : 1'($urandom_range(0, 1));
            if (b < 5) wait_write(40, n);
        end
    endtask

    task automatic test_host();
        int n;
        logic [7:0]  hl;
        logic [23:0] hd;
        do_reset();
        enable = 1'b1;
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            hl = (k == 0) ? 8'd2 : 8'($urandom_range(0, N-1));
            hd = (k == 0) ? 24'h123456 : 24'($urandom);
            host_write = 1'b1; host_led_num = hl; host_rgb_data = hd;
            checks++;
            if (host_ready !== 1'b1) begin
                errors++;
                $display("FAIL host_ready_wait k%0d: got %b, expected 1", k, host_ready);
            end
            tick();
            checks++;
            if ({write, led_num, rgb_data} !== {1'b1, hl, hd}) begin
                errors++;
                $display("FAIL host_wait k%0d: got wr=%b led=%0d rgb=%h, expected wr=1 led=%0d rgb=%h",
                         k, write, led_num, rgb_data, hl, hd);
            end
        end
        host_write = 1'b0;
        tick();
        wait_write(40, n);
        host_write = 1'b1; host_led_num = 8'd2; host_rgb_data = 24'h123456;
        for (int i = 0; i < N; i++) begin
            if (i > 0) tick();
            checks++;
            if ({host_ready, write, led_num, frame_done} !== {1'(i == N-1), 1'b1, 8'(i), 1'(i == N-1)}) begin
                errors++;
                $display("FAIL host_held i%0d: got rdy=%b wr=%b led=%0d fd=%b, expected rdy=%b wr=1 led=%0d fd=%b",
                         i, host_ready, write, led_num, frame_done, i == N-1, i, i == N-1);
            end
        end
        tick();
        host_write = 1'b0;
        checks++;
        if ({write, frame_done, led_num, rgb_data} !== {1'b1, 1'b0, 8'd2, 24'h123456}) begin
            errors++;
            $display("FAIL host_after_burst: got wr=%b fd=%b led=%0d rgb=%h, expected 1 0 2 123456",
                     write, frame_done, led_num, rgb_data);
        end
    endtask

    task automatic test_host_drop();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            enable = (k >= 2);
            host_write = 1'b1;
            host_led_num = (k == 0) ? 8'd7 : 8'($urandom_range(N, 255));
            host_rgb_data = $urandom;
            tick();
            checks++;
            if ({write, host_ready} !== 2'b01) begin
                errors++;
                $display("FAIL host_drop k%0d led%0d: got wr=%b rdy=%b, expected wr=0 rdy=1",
                         k, host_led_num, write, host_ready);
            end
        end
        host_write = 1'b0;
    endtask

    task automatic test_enable_drop();
        int n, cnt;
        logic [23:0] col;
        do_reset();
        colour = $urandom; col = colour; enable = 1'b1;
        wait_write(40, n);
        enable = 1'b0;
        capture_burst(col);
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({obs_wr[i], obs_led[i], obs_rgb[i]} !== {1'b1, 8'(i), exp_rgb(i, 0, col)}) begin
                errors++;
                $display("FAIL en_drop led%0d: got wr=%b led=%0d rgb=%h, expected wr=1 led=%0d rgb=%h",
                         i, obs_wr[i], obs_led[i], obs_rgb[i], i, exp_rgb(i, 0, col));
            end
        end
        cnt = 0;
        for (int k = 0; k < 3 * PERIOD; k++) begin
            tick();
            if (write) cnt++;
        end
        checks++;
        if ({cnt, host_ready} !== {32'd0, 1'b1}) begin
            errors++;
            $display("FAIL en_drop_idle: got writes=%0d rdy=%b, expected 0 1", cnt, host_ready);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [23:0] col;
        do_reset();
        colour = $urandom | 24'h1; col = colour; enable = 1'b1;
        wait_write(40, n);
        capture_burst(col);
        wait_write(40, n);
        tick();
        checks++;
        if ({write, led_num, rgb_data} !== {1'b1, 8'd1, col}) begin
            errors++;
            $display("FAIL rst_mid_pre: got wr=%b led=%0d rgb=%h, expected 1 1 %h", write, led_num, rgb_data, col);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({write, frame_done, led_num, rgb_data} !== {1'b0, 1'b0, 8'd0, 24'd0}) begin
            errors++;
            $display("FAIL rst_mid: got wr=%b fd=%b led=%0d rgb=%h, expected 0 0 0 000000",
                     write, frame_done, led_num, rgb_data);
        end
        wait_write(40, n);
        capture_burst(col);
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL rst_mid_restart: got %0d cycles, expected 12", n);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({obs_wr[i], obs_led[i], obs_rgb[i]} !== {1'b1, 8'(i), exp_rgb(i, 0, col)}) begin
                errors++;
                $display("FAIL rst_mid_burst led%0d: got wr=%b led=%0d rgb=%h, expected wr=1 led=%0d rgb=%h",
                         i, obs_wr[i], obs_led[i], obs_rgb[i], i, exp_rgb(i, 0, col));
            end
        end
    endtask

`ifdef WS2812_BRIGHTNESS_EN
    task automatic test_brightness();
        int n, b;
        logic [23:0] col;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            b   = (k == 0) ? 2 : int'($urandom_range(0, 7));
            col = (k == 0) ? 24'hFF8004 : 24'($urandom);
            do_reset();
            brightness = 3'(b); colour = col; enable = 1'b1;
            wait_write(40, n);
            capture_burst(col);
            checks++;
            if (obs_rgb[0] !== dim(col, b)) begin
                errors++;
                $display("FAIL bright k%0d b%0d: got %h, expected %h", k, b, obs_rgb[0], dim(col, b));
            end
        end
        host_write = 1'b1; host_led_num = 8'd1; host_rgb_data = 24'hFFFFFF;
        tick();
        host_write = 1'b0;
        checks++;
        if ({write, rgb_data} !== {1'b1, 24'hFFFFFF}) begin
            errors++;
            $display("FAIL bright_host: got wr=%b rgb=%h, expected 1 FFFFFF", write, rgb_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_chase();
        test_dir();
        test_host();
        test_host_drop();
        test_enable_drop();
        test_reset_mid();
`ifdef WS2812_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ws2812_chase_ctrl.md
Name: ws2812_chase_ctrl

Overview:
Sequencer that sits in front of the ws2812 driver and owns its write port (write, led_num, rgb_data).
Every FRAME_TICKS clocks it bursts a full frame into the driver's LED registers: one "head" LED lit with a chosen colour, all others off. The head then advances one position, giving a chase animation.
Between bursts it arbitrates the same write port to a host, so software can poke individual LEDs while the animation is paused or idle.

Parameters:
NUM_LEDS, 8, LED count; must match the driver; 2..255
FRAME_TICKS, 1200000, clocks between frame bursts (100 ms at 12 MHz); >= 2
CNT_W, 21, width of the frame tick counter; 2^CNT_W > FRAME_TICKS

Ports:
clk  in  1  system clock, 12 MHz
reset  in  1  synchronous, active-high
enable  in  1  1 = animation runs; 0 = idle after the current burst
dir  in  1  0 = head index increments, 1 = head index decrements
colour  in  24  GRB value for the head LED; sampled on entry to LOAD
host_write  in  1  host write request
host_led_num  in  8  host target LED
host_rgb_data  in  24  host colour
host_ready  out  1  combinational; host request accepted this cycle when high
frame_done  out  1  one-cycle pulse after the last LED of a burst is issued
write  out  1  to driver write; registered
led_num  out  8  to driver led_num; registered
rgb_data  out  24  to driver rgb_data; registered

Behaviour:
- Clocking/reset: one clock (clk). Reset is synchronous, active-high.
- Reset values: write=0, led_num=0, rgb_data=0, frame_done=0, head=0, idx=0, tick_cnt=0, state=IDLE.
- Reset asserted mid-burst aborts the burst; write=0 on the following cycle.
- States: IDLE, WAIT, LOAD.
- IDLE:
  - enable=1 -> WAIT, with tick_cnt <= FRAME_TICKS-1.
- WAIT:
  - tick_cnt decrements by 1 each cycle.
  - enable=0 -> IDLE (the counter is not preserved).
  - tick_cnt==0 with enable=1 -> LOAD, with idx <= 0 and the colour latch <= colour.
- LOAD, one LED per cycle:
  - registered outputs on the next cycle: write=1, led_num=idx, rgb_data = (idx==head) ? colour latch : 24'h0.
  - idx increments each cycle.
  - at idx==NUM_LEDS-1: frame_done=1 next cycle; head advances; state -> WAIT (tick_cnt reloaded) if enable=1, else -> IDLE.
  - enable falling mid-burst does not truncate the burst.
- Head advance and wrap:
  - dir=0: head+1, wrapping NUM_LEDS-1 -> 0.
  - dir=1: head-1, wrapping 0 -> NUM_LEDS-1.
  - dir is sampled only at the advance.
- Burst timing: exactly NUM_LEDS consecutive write pulses per burst. Burst-start period = FRAME_TICKS + NUM_LEDS + 1 clocks.
- Host arbitration:
  - host_ready = (state!=LOAD) && !(state==WAIT && tick_cnt==0 && enable).
  - accept = host_write && host_ready.
  - On accept: next cycle write=1, led_num=host_led_num, rgb_data=host_rgb_data.
  - host_led_num >= NUM_LEDS: request is consumed but dropped (write stays 0).
  - When host_ready=0, the host must hold its request until accepted.
  - The burst has priority; the host is never stalled longer than NUM_LEDS+1 cycles.
- Default: write=0 and frame_done=0 in any cycle with no issue.
- led_num/rgb_data hold their last value while write=0.

Optional Feature:
WS2812_BRIGHTNESS_EN
- Defined:
  - adds input port brightness[2:0].
  - each 8-bit channel of the colour latch is logically shifted right by brightness when latched on entry to LOAD.
  - brightness=0 leaves the colour unchanged; brightness=7 leaves at most 1 LSB per channel.
  - host writes are never scaled.
- Undefined: the port is absent; colour passes unmodified.

Decomposition:
- Package ws2812_pkg holds:
  - state enum (IDLE/WAIT/LOAD)
  - RGB_W=24, LED_IDX_W=8
  - shared driver timing constants (t_on, t_off, t_reset)
- One sub-module: ws2812_frame_timer (loadable down-counter with a zero flag), reused by future pattern controllers.
- The head/idx logic and the host arbitration stay in the top level.

Test Plan:
All cases use NUM_LEDS=4 and FRAME_TICKS=10.
1. Reset, enable=1, dir=0, colour=24'h00FF00 -> first write burst starts 11 cycles after enable. It gives led_num 0,1,2,3 with rgb 00FF00,0,0,0; frame_done pulses; the next burst lights led 1.
2. dir=1 from head=0 -> next burst lights led 3, then led 2: wrap-around on decrement.
3. Host request led 2 = 24'h123456 while in WAIT -> accepted the same cycle; write=1, led_num=2, rgb_data=123456 the next cycle. The same request issued during LOAD is held off with host_ready=0 and issued 1 cycle after frame_done.
4. Host request with led_num=7 -> no write pulse; host_ready stays 1.
5. enable dropped during the burst at idx=1 -> all 4 writes complete; state becomes IDLE; no further bursts. reset asserted at idx=2 -> write=0 the next cycle; the next burst lights led 0.
6. WS2812_BRIGHTNESS_EN, brightness=2, colour=24'hFF8004 -> head LED written as 24'h3F2001.
